// File: rtl/led_breathe_chaser_if.sv
// LED pin bundle for led_breathe_chaser: run enable in, five LED drives and
// the rotation-wrap pulse out.
interface led_breathe_chaser_if;
  logic en;
  logic D1;
  logic D2;
  logic D3;
  logic D4;
  logic D5;
  logic cycle_done;

  // Controller side: drives enable, observes the LEDs.
  modport master (
    output en,
    input  D1,
    input  D2,
    input  D3,
    input  D4,
    input  D5,
    input  cycle_done
  );

  // Chaser side: samples enable, drives the LEDs.
  modport slave (
    input  en,
    output D1,
    output D2,
    output D3,
    output D4,
    output D5,
    output cycle_done
  );
endinterface

// File: rtl/led_breathe_chaser.sv
// Breathing PWM chaser: one of five LEDs ramps its duty up to full, back down
// to dark, idles one dark period, then hands off to the next LED in rotation.
module led_breathe_chaser #(
  parameter int unsigned PRESCALE = 48,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP     = 4
) (
  input logic                 clk,
  input logic                 rst,
  led_breathe_chaser_if.slave bus
);

  localparam int unsigned PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0]   PCNT_LAST = PCNT_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] MAX       = '1;
  // Saturation math runs one bit wider so neither direction can wrap.
  localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS + 1)'(STEP);
  localparam logic [PWM_BITS:0]   MAX_W     = {1'b0, MAX};

  typedef enum logic [1:0] {StIdle, StRise, StFall, StNext} state_e;

  state_e              state_q, state_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [2:0]          ch_q, ch_d;
  logic [4:0]          led_q, led_d;
  logic                cycle_done_q, cycle_done_d;

  logic                tick;
  logic                pend;
  logic                on;
  logic [PWM_BITS:0]   duty_up;
  logic [PWM_BITS:0]   duty_dn;
  logic [PWM_BITS-1:0] rise_val;
  logic [PWM_BITS-1:0] fall_val;

  // Period timing, PWM compare and saturated duty candidates.
  always_comb begin
    tick     = (pcnt_q == PCNT_LAST);
    pend     = tick && (pwm_cnt_q == MAX);
    on       = (pwm_cnt_q < duty_q);
    duty_up  = {1'b0, duty_q} + STEP_W;
    duty_dn  = {1'b0, duty_q} - STEP_W;
    rise_val = (duty_up >= MAX_W) ? MAX : duty_up[PWM_BITS-1:0];
    // A set top bit means the subtraction borrowed: clamp at dark.
    fall_val = duty_dn[PWM_BITS] ? '0 : duty_dn[PWM_BITS-1:0];
  end

  // Next-state logic for the ramp FSM, counters, duty and channel.
  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    pwm_cnt_d    = pwm_cnt_q;
    duty_d       = duty_q;
    ch_d         = ch_q;
    cycle_done_d = 1'b0;

    if (state_q != StIdle) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      if (tick) begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        pcnt_d    = '0;
        pwm_cnt_d = '0;
        duty_d    = '0;
        if (bus.en) begin
          state_d = StRise;
        end
      end
      StRise: begin
        if (pend) begin
          duty_d = rise_val;
          if (rise_val == MAX) begin
            state_d = StFall;
          end
        end
      end
      StFall: begin
        if (pend) begin
          duty_d = fall_val;
          if (fall_val == '0) begin
            state_d = StNext;
          end
        end
      end
      StNext: begin
        // Duty is already 0 here, so this whole period is dark.
        if (pend) begin
          state_d = StRise;
          if (ch_q == 3'd4) begin
            ch_d         = 3'd0;
            cycle_done_d = 1'b1;
          end else begin
            ch_d = ch_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Dropping enable abandons all ramp progress but keeps the channel.
    if ((state_q != StIdle) && !bus.en) begin
      state_d      = StIdle;
      pcnt_d       = '0;
      pwm_cnt_d    = '0;
      duty_d       = '0;
      ch_d         = ch_q;
      cycle_done_d = 1'b0;
    end
  end

  // Route the compare result to the active LED only.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < 5; i++) begin
      led_d[i] = on && (ch_q == 3'(i));
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pcnt_q       <= '0;
      pwm_cnt_q    <= '0;
      duty_q       <= '0;
      ch_q         <= 3'd0;
      led_q        <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      duty_q       <= duty_d;
      ch_q         <= ch_d;
      led_q        <= led_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign bus.D1         = led_q[0];
  assign bus.D2         = led_q[1];
  assign bus.D3         = led_q[2];
  assign bus.D4         = led_q[3];
  assign bus.D5         = led_q[4];
  assign bus.cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_breathe_chaser.sv
// Bench for led_breathe_chaser: two instances (STEP=2 and STEP=7) run in lockstep
// against a period-level reference model, plus directed profile/rotation checks.
module tb_led_breathe_chaser;

  localparam int PRESC = 2;
  localparam int MAXV  = 7;
  localparam int PER   = 16;

  logic clk;
  logic rst;

  led_breathe_chaser_if bus_a ();
  led_breathe_chaser_if bus_b ();

  led_breathe_chaser #(.PRESCALE(2), .PWM_BITS(3), .STEP(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  led_breathe_chaser #(.PRESCALE(2), .PWM_BITS(3), .STEP(7)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Reference model state per instance.
  bit       run_m  [2];
  int       t_m    [2];
  int       ch_m   [2];
  logic [4:0] exp_d [2];
  logic     exp_cd [2];

  int prof [9] = '{0, 4, 8, 12, 14, 10, 6, 2, 0};
  int prof_b [3] = '{0, 14, 0};
  int hi [9];
  int hi_b [3];
  int d1_first = -1, d2_first = -1, b2_first = -1, cd_first = -1, cd_count = 0;
  int d1_again = -1, multi = 0, first_lit = -1, d3_cnt = 0;
  logic [4:0] which_lit;

  // Duty of period k in one LED's ramp (k < 0 returns the period count).
  function automatic int gen(input int step, input int k);
    int seq[$];
    int d;
    d = 0;
    do begin
      seq.push_back(d);
      d = (d + step > MAXV) ? MAXV : d + step;
    end while (d != MAXV);
    do begin
      seq.push_back(d);
      d = (d > step) ? d - step : 0;
    end while (d != 0);
    seq.push_back(0);
    if (k < 0) return seq.size();
    return seq[k];
  endfunction

  function automatic bit on_at(input int step, input int t);
    int k, pwm;
    k   = t / PER;
    pwm = (t % PER) / PRESC;
    return pwm < gen(step, k);
  endfunction

  function automatic logic [4:0] leds_a();
    return {bus_a.D5, bus_a.D4, bus_a.D3, bus_a.D2, bus_a.D1};
  endfunction

  function automatic logic [4:0] leds_b();
    return {bus_b.D5, bus_b.D4, bus_b.D3, bus_b.D2, bus_b.D1};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      run_m[i]  = 1'b0;
      t_m[i]    = 0;
      ch_m[i]   = 0;
      exp_d[i]  = '0;
      exp_cd[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int i, input logic en_v);
    int s;
    s         = (i == 0) ? 2 : 7;
    exp_d[i]  = '0;
    exp_cd[i] = 1'b0;
    if (run_m[i]) begin
      if (on_at(s, t_m[i])) exp_d[i][ch_m[i]] = 1'b1;
      if (!en_v) begin
        run_m[i] = 1'b0;
        t_m[i]   = 0;
      end else begin
        t_m[i]++;
        if (t_m[i] == gen(s, -1) * PER) begin
          t_m[i]    = 0;
          exp_cd[i] = (ch_m[i] == 4);
          ch_m[i]   = (ch_m[i] + 1) % 5;
        end
      end
    end else if (en_v) begin
      run_m[i] = 1'b1;
      t_m[i]   = 0;
    end
  endtask

  task automatic check(input string tag);
    logic [4:0] got;
    logic       cd;
    for (int i = 0; i < 2; i++) begin
      got = (i == 0) ? leds_a() : leds_b();
      cd  = (i == 0) ? bus_a.cycle_done : bus_b.cycle_done;
      tests++;
      assert (got === exp_d[i]) else begin
        fails++;
        $error("FAIL %s_leds[%0d] got %b want %b", tag, i, got, exp_d[i]);
      end
      tests++;
      assert (cd === exp_cd[i]) else begin
        fails++;
        $error("FAIL %s_cycle_done[%0d] got %b want %b", tag, i, cd, exp_cd[i]);
      end
    end
  endtask

  task automatic cmp(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  // Called between edges; drives en, takes one posedge, checks #1 later.
  task automatic cycle(input logic en_v);
    bus_a.en = en_v;
    bus_b.en = en_v;
    @(posedge clk);
    model_edge(0, en_v);
    model_edge(1, en_v);
    #1;
    check("run");
  endtask

  // Asserts reset mid-cycle, checks outputs cleared at once, releases before next edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst");
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    bus_a.en = 1'b0;
    bus_b.en = 1'b0;
    model_reset();
    #1;
    check("por");
    #1;
    rst = 1'b0;

    // Reset while D1 is lit.
    for (int n = 0; n < 19; n++) cycle(1'b1);
    cmp("d1_lit_before_reset", int'(bus_a.D1), 1);
    async_reset();

    // Ramp profile, rotation and wrap from a fresh start.
    for (int n = 0; n <= 745; n++) begin
      cycle(1'b1);
      if (n >= 1 && n <= 144) hi[(n - 1) / PER] += int'(bus_a.D1);
      if (n >= 1 && n <= 48) hi_b[(n - 1) / PER] += int'(bus_b.D1);
      if (bus_a.D1 && d1_first < 0) d1_first = n;
      if (bus_a.D2 && d2_first < 0) d2_first = n;
      if (bus_b.D2 && b2_first < 0) b2_first = n;
      if (n > 720 && bus_a.D1 && d1_again < 0) d1_again = n;
      if (bus_a.cycle_done) begin
        cd_count++;
        if (cd_first < 0) cd_first = n;
      end
      if ($countones(leds_a()) > 1 || $countones(leds_b()) > 1) multi++;
    end
    for (int k = 0; k < 9; k++) cmp($sformatf("d1_profile_p%0d", k), hi[k], prof[k]);
    for (int k = 0; k < 3; k++) cmp($sformatf("step7_profile_p%0d", k), hi_b[k], prof_b[k]);
    cmp("d1_first_high", d1_first, 17);
    cmp("d2_first_high", d2_first, d1_first + 144);
    cmp("step7_d2_first_high", b2_first, 17 + 48);
    cmp("cycle_done_at", cd_first, 720);
    cmp("cycle_done_pulses", cd_count, 1);
    cmp("d1_again", d1_again, 720 + 17);
    cmp("multi_lit", multi, 0);

    // Enable drop during D3 fall.
    for (int n = 746; n <= 1080; n++) cycle(1'b1);
    cmp("d3_fall_lit", int'(bus_a.D3), 1);
    cycle(1'b0);
    cycle(1'b0);
    cmp("idle_dark", int'(leds_a()), 0);
    for (int n = 0; n < 3; n++) cycle(1'b0);
    for (int n = 0; n <= 40; n++) begin
      cycle(1'b1);
      if (leds_a() != 5'b0 && first_lit < 0) begin
        first_lit = n;
        which_lit = leds_a();
      end
      if (n >= 1 && n <= 32) d3_cnt += int'(bus_a.D3);
    end
    cmp("reenable_first_lit", first_lit, 17);
    cmp("reenable_led", int'(which_lit), 4);
    cmp("reenable_d3_count", d3_cnt, 4);

    // Randomized enable with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
